mem_arbiter: RTL

Parametrised N-channel stb/ack memory arbiter that merges the core's requester ports (instruction fetch, data load/store, future DMA or debug masters) onto one downstream memory port. Successor to the core's fixed split of separate i-mem and d-mem ports: channel count, address/data width, arbitration mode and a bus-timeout are all configurable. Sits between core-level master ports and a single shared memory or bus slave.

---
 rtl/mem_arbiter_pkg.sv | 21 ++
 rtl/mem_arbiter_rr_pick.sv | 30 +++
 rtl/mem_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the N-channel stb/ack memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arbiter_pkg;

   // Arbiter FSM encodings
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Fill bit for read data returned on a timed-out transfer
   localparam logic ERR_RDATA_BIT = 1'b0;

   // Index width for an N-entry selection, never narrower than one bit
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Rotating priority encoder: first set request at or after start, wrapping.
// Latency: combinational.
// Backpressure: none; vld low when no request is set.
module rr_pick #(
   parameter int N  = 2,
   parameter int IW = 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] start,
   output logic          vld,
   output logic [IW-1:0] idx
);

   // Scan from farthest to nearest so the nearest hit to start is the last write
   always_comb begin
      int k;
      vld = 1'b0;
      idx = '0;
      k   = 0;
      for (int i = N - 1; i >= 0; i--) begin
         k = int'(start) + i;
         if (k >= N) k = k - N;
         if (req[k]) begin
            vld = 1'b1;
            idx = IW'(k);
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// N-channel stb/ack arbiter merging requester ports onto one memory port.
// Latency: request to o_m_stb 1 cycle, slave ack to o_ack 1 cycle, 3 cycles minimum per transfer.
// Backpressure: requesters hold stb until acked; slave wait states stretch BUS, optional timeout.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int NCH     = 2,
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int RR_MODE = 1,
   parameter int TIMEOUT = 0
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic [NCH-1:0]                         i_stb,
   input  logic [NCH-1:0]                         i_wr_en,
   input  logic [NCH*AW-1:0]                      i_addr,
   input  logic [NCH*DW-1:0]                      i_wdata,
   output logic [NCH-1:0]                         o_ack,
   output logic [NCH-1:0]                         o_err,
   output logic [DW-1:0]                          o_rdata,
   output logic                                   o_m_stb,
   output logic                                   o_m_wr_en,
   output logic [AW-1:0]                          o_m_addr,
   output logic [DW-1:0]                          o_m_wdata,
   input  logic                                   i_m_ack,
   input  logic [DW-1:0]                          i_m_rdata,
   output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] o_grant,
   output logic                                   o_busy
);

   localparam int GW = idx_width(NCH);
   // Counter holds 0..TIMEOUT-1 cycles already spent in BUS without an ack
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_t         state_q, state_d;
   logic [GW-1:0]  ptr_q, grant_q, pick_idx, pick_start;
   logic           pick_vld;
   logic           wr_q, err_q;
   logic [AW-1:0]  addr_q;
   logic [DW-1:0]  wdata_q, rdata_q;
   logic [CW-1:0]  cnt_q;
   logic           timeout_hit;

   // Fixed priority is round-robin with the search pinned to channel 0
   assign pick_start = (RR_MODE != 0) ? ptr_q : '0;

   rr_pick #(.N(NCH), .IW(GW)) u_pick (
      .req   (i_stb),
      .start (pick_start),
      .vld   (pick_vld),
      .idx   (pick_idx)
   );

   assign timeout_hit = (TIMEOUT > 0) && (cnt_q == CW'(TIMEOUT - 1));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state: grant in IDLE, leave BUS on ack or timeout, RESP lasts one cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (pick_vld) state_d = ST_BUS;
         ST_BUS:  if (i_m_ack || timeout_hit) state_d = ST_RESP;
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Transfer fields latched at grant, response captured at BUS exit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q   <= '0;
         grant_q <= '0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (pick_vld) begin
                  grant_q <= pick_idx;
                  wr_q    <= i_wr_en[pick_idx];
                  addr_q  <= i_addr[pick_idx*AW +: AW];
                  wdata_q <= i_wdata[pick_idx*DW +: DW];
                  err_q   <= 1'b0;
                  cnt_q   <= '0;
                  if (RR_MODE != 0)
                     ptr_q <= (pick_idx == GW'(NCH - 1)) ? '0 : pick_idx + 1'b1;
               end
            end
            ST_BUS: begin
               if (i_m_ack) begin
                  rdata_q <= i_m_rdata;
                  err_q   <= 1'b0;
               end else if (timeout_hit) begin
                  rdata_q <= {DW{ERR_RDATA_BIT}};
                  err_q   <= 1'b1;
               end else begin
                  cnt_q   <= cnt_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Moore outputs decoded from the state register; late acks outside BUS fall through
   always_comb begin
      o_m_stb = (state_q == ST_BUS);
      o_busy  = (state_q != ST_IDLE);
      o_ack   = '0;
      o_err   = '0;
      if (state_q == ST_RESP) begin
         o_ack[grant_q] = 1'b1;
         o_err[grant_q] = err_q;
      end
   end

   assign o_m_wr_en = wr_q;
   assign o_m_addr  = addr_q;
   assign o_m_wdata = wdata_q;
   assign o_rdata   = rdata_q;
   assign o_grant   = grant_q;

endmodule
